// File: rtl/zrle_pkg.sv
// Shared types and constants for the ZRL engine arbiter.
// Optional feature macro: ZRLE_ARB_STATS_EN (per-channel packet counters).
package zrle_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    LOCK = 1'b1
  } state_t;

  localparam int DATA_W = 64;
  localparam int CNT_W  = 16;

endpackage

// File: rtl/zrle_rr_sel.sv
// Round-robin first-requester search starting at rr_ptr; one-hot grant out.
// Rotates the request vector down by rr_ptr, takes the lowest set bit, rotates back.
module zrle_rr_sel #(
  parameter int N_CH  = 4,
  parameter int CID_W = 2
) (
  input  logic [N_CH-1:0]  req,
  input  logic [CID_W-1:0] rr_ptr,
  output logic [N_CH-1:0]  grant,
  output logic             found
);

  logic [N_CH-1:0] rot;
  logic [N_CH-1:0] rot_first;
  logic [N_CH-1:0] seen;

  assign rot = N_CH'({req, req} >> rr_ptr);

  assign seen[0] = 1'b0;
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_prio
    assign rot_first[gi] = rot[gi] & ~seen[gi];
    if (gi < N_CH - 1) begin : g_chain
      assign seen[gi+1] = seen[gi] | rot[gi];
    end
  end

  assign grant = N_CH'(({rot_first, rot_first} << rr_ptr) >> N_CH);
  assign found = |req;

endmodule

// File: rtl/zrle_arbiter.sv
// Packet-level round-robin arbiter feeding N_CH requesters into one ZRL engine.
// Optional feature macro: ZRLE_ARB_STATS_EN adds pkt_cnt_o per-channel eop counters.
module zrle_arbiter #(
  parameter int N_CH   = 4,
  parameter int DATA_W = zrle_pkg::DATA_W,
  parameter int CID_W  = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_CH*DATA_W-1:0]   ch_data_i,
  input  logic [N_CH-1:0]          ch_valid_i,
  input  logic [N_CH-1:0]          ch_sop_i,
  input  logic [N_CH-1:0]          ch_eop_i,
  output logic [N_CH-1:0]          ch_ready_o,
  output logic [DATA_W-1:0]        eng_data_o,
  output logic                     eng_valid_o,
  output logic                     eng_sop_o,
  output logic                     eng_eop_o,
  output logic [CID_W-1:0]         eng_ch_o,
  input  logic                     eng_ready_i,
  output logic                     busy_o,
  output logic                     err_o
`ifdef ZRLE_ARB_STATS_EN
  ,
  output logic [N_CH*zrle_pkg::CNT_W-1:0] pkt_cnt_o
`endif
);

  import zrle_pkg::*;

  state_t             state_reg, state_next;
  logic [CID_W-1:0]   grant_reg, grant_next;
  logic [CID_W-1:0]   rr_ptr_reg, rr_ptr_next;
  logic               first_reg, first_next;
  logic               err_reg, err_next;

  logic               eng_valid_reg;
  logic               eng_sop_reg;
  logic               eng_eop_reg;
  logic [DATA_W-1:0]  eng_data_reg;
  logic [CID_W-1:0]   eng_ch_reg;

  logic               slot_free;
  logic               load;
  logic [N_CH-1:0]    sop_req;
  logic [N_CH-1:0]    bad_req;
  logic [N_CH-1:0]    bad_first;
  logic [N_CH-1:0]    bad_seen;
  logic [N_CH-1:0]    sel_oh;
  logic               sel_found;
  logic [CID_W-1:0]   sel_idx;
  logic [N_CH-1:0]    grant_oh;
  logic [N_CH-1:0]    ch_ready;
  logic               g_valid;
  logic               g_sop;
  logic               g_eop;
  logic [DATA_W-1:0]  g_data;

  logic [CID_W-1:0]   idx_acc  [N_CH+1];
  logic [DATA_W-1:0]  data_acc [N_CH+1];

  assign sop_req   = ch_valid_i & ch_sop_i;
  assign bad_req   = ch_valid_i & ~ch_sop_i;
  assign slot_free = ~eng_valid_reg | eng_ready_i;

  zrle_rr_sel #(
    .N_CH  (N_CH),
    .CID_W (CID_W)
  ) u_rr_sel (
    .req    (sop_req),
    .rr_ptr (rr_ptr_reg),
    .grant  (sel_oh),
    .found  (sel_found)
  );

  // Per-channel decode: lowest stray word, one-hot to index, granted-word mux.
  assign bad_seen[0] = 1'b0;
  assign idx_acc[0]  = '0;
  assign data_acc[0] = '0;
  for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
    assign bad_first[gi]  = bad_req[gi] & ~bad_seen[gi];
    if (gi < N_CH - 1) begin : g_chain
      assign bad_seen[gi+1] = bad_seen[gi] | bad_req[gi];
    end
    assign grant_oh[gi]   = (grant_reg == CID_W'(gi));
    assign idx_acc[gi+1]  = idx_acc[gi] | (sel_oh[gi] ? CID_W'(gi) : '0);
    assign data_acc[gi+1] = data_acc[gi] |
                            (grant_oh[gi] ? ch_data_i[gi*DATA_W +: DATA_W] : '0);
  end

  assign sel_idx = idx_acc[N_CH];
  assign g_data  = data_acc[N_CH];
  assign g_valid = |(ch_valid_i & grant_oh);
  assign g_sop   = |(ch_sop_i & grant_oh);
  assign g_eop   = |(ch_eop_i & grant_oh);

  always_comb begin
    state_next  = state_reg;
    grant_next  = grant_reg;
    rr_ptr_next = rr_ptr_reg;
    first_next  = first_reg;
    err_next    = 1'b0;
    ch_ready    = '0;
    load        = 1'b0;
    case (state_reg)
      IDLE: begin
        // Words arriving without sop are drained and flagged, one channel per cycle.
        ch_ready = bad_first;
        err_next = |bad_req;
        if (sel_found) begin
          grant_next = sel_idx;
          first_next = 1'b1;
          state_next = LOCK;
        end
      end
      LOCK: begin
        if (slot_free) begin
          ch_ready = grant_oh;
          if (g_valid) begin
            load       = 1'b1;
            first_next = 1'b0;
            if (g_sop && !first_reg) begin
              err_next = 1'b1;
            end
            if (g_eop) begin
              state_next  = IDLE;
              rr_ptr_next = (grant_reg == CID_W'(N_CH - 1)) ? '0 : grant_reg + CID_W'(1);
            end
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      grant_reg  <= '0;
      rr_ptr_reg <= '0;
      first_reg  <= 1'b0;
      err_reg    <= 1'b0;
    end else begin
      state_reg  <= state_next;
      grant_reg  <= grant_next;
      rr_ptr_reg <= rr_ptr_next;
      first_reg  <= first_next;
      err_reg    <= err_next;
    end
  end

  // Single output stage; contents hold while the engine stalls.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      eng_valid_reg <= 1'b0;
      eng_sop_reg   <= 1'b0;
      eng_eop_reg   <= 1'b0;
      eng_data_reg  <= '0;
      eng_ch_reg    <= '0;
    end else if (load) begin
      eng_valid_reg <= 1'b1;
      eng_sop_reg   <= g_sop;
      eng_eop_reg   <= g_eop;
      eng_data_reg  <= g_data;
      eng_ch_reg    <= grant_reg;
    end else if (eng_ready_i) begin
      eng_valid_reg <= 1'b0;
    end
  end

`ifdef ZRLE_ARB_STATS_EN
  logic eop_fire;
  assign eop_fire = eng_valid_reg & eng_ready_i & eng_eop_reg;

  for (genvar gi = 0; gi < N_CH; gi++) begin : g_stats
    logic [CNT_W-1:0] cnt_reg;
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        cnt_reg <= '0;
      end else if (eop_fire && (eng_ch_reg == CID_W'(gi))) begin
        cnt_reg <= cnt_reg + 1'b1;
      end
    end
    assign pkt_cnt_o[gi*CNT_W +: CNT_W] = cnt_reg;
  end
`endif

  // Ready is combinational, so it is masked while reset is held.
  assign ch_ready_o  = ch_ready & {N_CH{~rst}};
  assign eng_valid_o = eng_valid_reg;
  assign eng_sop_o   = eng_sop_reg;
  assign eng_eop_o   = eng_eop_reg;
  assign eng_data_o  = eng_data_reg;
  assign eng_ch_o    = eng_ch_reg;
  assign busy_o      = (state_reg == LOCK);
  assign err_o       = err_reg;

endmodule

// File: tb/tb_zrle_arbiter.sv
// Directed bench for zrle_arbiter: cycle-by-cycle vector table plus packet sequences.
// Optional feature macro: ZRLE_ARB_STATS_EN enables the packet-counter checks.
module tb_zrle_arbiter;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [255:0]  ch_data_i;
  logic [3:0]    ch_valid_i;
  logic [3:0]    ch_sop_i;
  logic [3:0]    ch_eop_i;
  logic [3:0]    ch_ready_o;
  logic [63:0]   eng_data_o;
  logic          eng_valid_o;
  logic          eng_sop_o;
  logic          eng_eop_o;
  logic [1:0]    eng_ch_o;
  logic          eng_ready_i;
  logic          busy_o;
  logic          err_o;
`ifdef ZRLE_ARB_STATS_EN
  logic [63:0]   pkt_cnt_o;
`endif

  always #5 clk = ~clk;

  zrle_arbiter #(
    .N_CH   (4),
    .DATA_W (64),
    .CID_W  (2)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ch_data_i   (ch_data_i),
    .ch_valid_i  (ch_valid_i),
    .ch_sop_i    (ch_sop_i),
    .ch_eop_i    (ch_eop_i),
    .ch_ready_o  (ch_ready_o),
    .eng_data_o  (eng_data_o),
    .eng_valid_o (eng_valid_o),
    .eng_sop_o   (eng_sop_o),
    .eng_eop_o   (eng_eop_o),
    .eng_ch_o    (eng_ch_o),
    .eng_ready_i (eng_ready_i),
    .busy_o      (busy_o),
    .err_o       (err_o)
`ifdef ZRLE_ARB_STATS_EN
    ,
    .pkt_cnt_o   (pkt_cnt_o)
`endif
  );

  typedef struct {
    logic        rst;
    logic [3:0]  v;
    logic [3:0]  s;
    logic [3:0]  e;
    logic [63:0] t;
    logic [3:0]  x_rdy;
    logic        x_ev;
    logic        x_es;
    logic        x_ee;
    logic [1:0]  x_ch;
    logic [15:0] x_d;
    logic        x_busy;
    logic        x_err;
  } vec_t;

  vec_t tbl[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  logic [63:0] got_d [16];
  logic        got_s [16];
  logic        got_e [16];
  logic [1:0]  got_c [16];

  function automatic vec_t mk(logic r, logic [3:0] v, logic [3:0] s, logic [3:0] e,
                              logic [63:0] t, logic [3:0] xr, logic xev, logic xes,
                              logic xee, logic [1:0] xch, logic [15:0] xd,
                              logic xb, logic xerr);
    vec_t m;
    m.rst = r; m.v = v; m.s = s; m.e = e; m.t = t;
    m.x_rdy = xr; m.x_ev = xev; m.x_es = xes; m.x_ee = xee;
    m.x_ch = xch; m.x_d = xd; m.x_busy = xb; m.x_err = xerr;
    return m;
  endfunction

  function automatic logic [63:0] tg(logic [15:0] a0, logic [15:0] a1,
                                     logic [15:0] a2, logic [15:0] a3);
    return {a3, a2, a1, a0};
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  // Drives one packet on channel ch as a well-behaved source and records engine words.
  task automatic run_pkt(input int ch, input int n, input logic [15:0] base,
                         input int stall_at, input int stall_len, input int rst_after,
                         output int got_n);
    int          idx;
    logic [63:0] held;
    bit          stall_seen;
    bit          acc_ch;
    bit          acc_eng;
    bit          done;
    idx = 0; got_n = 0; stall_seen = 0; held = '0; done = 0;
    for (int cyc = 0; cyc < 200 && !done; cyc++) begin
      @(negedge clk);
      ch_valid_i = '0; ch_sop_i = '0; ch_eop_i = '0;
      if (idx < n) begin
        ch_valid_i[ch] = 1'b1;
        ch_sop_i[ch]   = (idx == 0);
        ch_eop_i[ch]   = (idx == n - 1);
        ch_data_i[ch*64 +: 64] = {48'h0, base + 16'(idx)};
      end
      eng_ready_i = !(cyc >= stall_at && cyc < stall_at + stall_len);
      #1;
      if (!eng_ready_i && eng_valid_o) begin
        if (stall_seen) chk("stall_hold", eng_data_o, held);
        chk("stall_ready", 64'(ch_ready_o), 64'h0);
        held = eng_data_o;
        stall_seen = 1;
      end
      acc_eng = eng_valid_o && eng_ready_i;
      acc_ch  = ch_valid_i[ch] && ch_ready_o[ch];
      if (acc_eng && got_n < 16) begin
        got_d[got_n] = eng_data_o;
        got_s[got_n] = eng_sop_o;
        got_e[got_n] = eng_eop_o;
        got_c[got_n] = eng_ch_o;
        got_n++;
      end
      if (acc_ch) idx++;
      if (rst_after > 0 && idx == rst_after) begin
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("rst_eng_valid", 64'(eng_valid_o), 64'h0);
        chk("rst_eng_sop",   64'(eng_sop_o),   64'h0);
        chk("rst_eng_eop",   64'(eng_eop_o),   64'h0);
        chk("rst_eng_data",  eng_data_o,       64'h0);
        chk("rst_eng_ch",    64'(eng_ch_o),    64'h0);
        chk("rst_err",       64'(err_o),       64'h0);
        chk("rst_busy",      64'(busy_o),      64'h0);
        chk("rst_ch_ready",  64'(ch_ready_o),  64'h0);
        @(negedge clk);
        rst = 1'b0;
        done = 1;
      end else if (got_n == n) begin
        done = 1;
      end
    end
    ch_valid_i = '0; ch_sop_i = '0; ch_eop_i = '0;
    eng_ready_i = 1'b1;
    if (rst_after > 0) chk("rst_reached", 64'(idx), 64'(rst_after));
    else               chk("pkt_words", 64'(got_n), 64'(n));
  endtask

  task automatic check_pkt(input int ch, input int n, input logic [15:0] base, input int got_n);
    for (int i = 0; i < n && i < got_n; i++) begin
      chk($sformatf("pkt_data[%0d]", i), got_d[i], {48'h0, base + 16'(i)});
      chk($sformatf("pkt_sop[%0d]", i),  64'(got_s[i]), 64'(i == 0));
      chk($sformatf("pkt_eop[%0d]", i),  64'(got_e[i]), 64'(i == n - 1));
      chk($sformatf("pkt_ch[%0d]", i),   64'(got_c[i]), 64'(ch));
    end
  endtask

  int b_last;
  int gn;

  initial begin
    ch_data_i = '0; ch_valid_i = '0; ch_sop_i = '0; ch_eop_i = '0;
    eng_ready_i = 1'b1;
    repeat (2) @(negedge clk);

    // Reset, then single-word sop&eop packet on ch1.
    tbl.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 64'h0,               4'b0000, 0, 0, 0, 0, 16'h0,   0, 0));
    tbl.push_back(mk(0, 4'b0010, 4'b0010, 4'b0010, tg(0, 16'h1, 0, 0), 4'b0000, 0, 0, 0, 0, 16'h0,   0, 0));
    tbl.push_back(mk(0, 4'b0010, 4'b0010, 4'b0010, tg(0, 16'h1, 0, 0), 4'b0010, 0, 0, 0, 0, 16'h0,   1, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 64'h0,               4'b0000, 1, 1, 1, 1, 16'h1,   0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 64'h0,               4'b0000, 0, 0, 0, 0, 16'h0,   0, 0));
    // Reset, then ch0 and ch2 contend with 3-word packets.
    tbl.push_back(mk(1, 4'b0000, 4'b0000, 4'b0000, 64'h0,               4'b0000, 0, 0, 0, 0, 16'h0,   0, 0));
    tbl.push_back(mk(0, 4'b0101, 4'b0101, 4'b0000, tg(16'hA0, 0, 16'hC0, 0), 4'b0000, 0, 0, 0, 0, 16'h0,  0, 0));
    tbl.push_back(mk(0, 4'b0101, 4'b0101, 4'b0000, tg(16'hA0, 0, 16'hC0, 0), 4'b0001, 0, 0, 0, 0, 16'h0,  1, 0));
    tbl.push_back(mk(0, 4'b0101, 4'b0100, 4'b0000, tg(16'hA1, 0, 16'hC0, 0), 4'b0001, 1, 1, 0, 0, 16'hA0, 1, 0));
    tbl.push_back(mk(0, 4'b0101, 4'b0100, 4'b0001, tg(16'hA2, 0, 16'hC0, 0), 4'b0001, 1, 0, 0, 0, 16'hA1, 1, 0));
    tbl.push_back(mk(0, 4'b0100, 4'b0100, 4'b0000, tg(0, 0, 16'hC0, 0),      4'b0000, 1, 0, 1, 0, 16'hA2, 0, 0));
    tbl.push_back(mk(0, 4'b0100, 4'b0100, 4'b0000, tg(0, 0, 16'hC0, 0),      4'b0100, 0, 0, 0, 0, 16'h0,  1, 0));
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 4'b0000, tg(0, 0, 16'hC1, 0),      4'b0100, 1, 1, 0, 2, 16'hC0, 1, 0));
    tbl.push_back(mk(0, 4'b0100, 4'b0000, 4'b0100, tg(0, 0, 16'hC2, 0),      4'b0100, 1, 0, 0, 2, 16'hC1, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 64'h0,                    4'b0000, 1, 0, 1, 2, 16'hC2, 0, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 64'h0,                    4'b0000, 0, 0, 0, 0, 16'h0,  0, 0));
    b_last = tbl.size() - 1;
    // ch3 packet whose second word repeats sop (also eop): forwarded, err pulses once.
    tbl.push_back(mk(0, 4'b1000, 4'b1000, 4'b0000, tg(0, 0, 0, 16'h30), 4'b0000, 0, 0, 0, 0, 16'h0,  0, 0));
    tbl.push_back(mk(0, 4'b1000, 4'b1000, 4'b0000, tg(0, 0, 0, 16'h30), 4'b1000, 0, 0, 0, 0, 16'h0,  1, 0));
    tbl.push_back(mk(0, 4'b1000, 4'b1000, 4'b1000, tg(0, 0, 0, 16'h31), 4'b1000, 1, 1, 0, 3, 16'h30, 1, 0));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 64'h0,               4'b0000, 1, 1, 1, 3, 16'h31, 0, 1));
    tbl.push_back(mk(0, 4'b0000, 4'b0000, 4'b0000, 64'h0,               4'b0000, 0, 0, 0, 0, 16'h0,  0, 0));

    for (int i = 0; i < tbl.size(); i++) begin
      @(negedge clk);
      rst        = tbl[i].rst;
      ch_valid_i = tbl[i].v;
      ch_sop_i   = tbl[i].s;
      ch_eop_i   = tbl[i].e;
      for (int k = 0; k < 4; k++) ch_data_i[k*64 +: 64] = {48'h0, tbl[i].t[k*16 +: 16]};
      #1;
      chk($sformatf("v%0d.ch_ready", i), 64'(ch_ready_o),  64'(tbl[i].x_rdy));
      chk($sformatf("v%0d.eng_valid", i), 64'(eng_valid_o), 64'(tbl[i].x_ev));
      chk($sformatf("v%0d.busy", i),      64'(busy_o),      64'(tbl[i].x_busy));
      chk($sformatf("v%0d.err", i),       64'(err_o),       64'(tbl[i].x_err));
      if (tbl[i].x_ev) begin
        chk($sformatf("v%0d.eng_sop", i),  64'(eng_sop_o), 64'(tbl[i].x_es));
        chk($sformatf("v%0d.eng_eop", i),  64'(eng_eop_o), 64'(tbl[i].x_ee));
        chk($sformatf("v%0d.eng_ch", i),   64'(eng_ch_o),  64'(tbl[i].x_ch));
        chk($sformatf("v%0d.eng_data", i), eng_data_o,     {48'h0, tbl[i].x_d});
      end
      if (i == b_last) chk("rr_ptr_after_contention", 64'(dut.rr_ptr_reg), 64'd3);
    end
    rst = 1'b0;
    ch_valid_i = '0; ch_sop_i = '0; ch_eop_i = '0;

    // Stray word on ch3 while idle: drained, err for exactly one cycle, nothing forwarded.
    @(negedge clk);
    ch_valid_i = 4'b1000;
    ch_data_i[3*64 +: 64] = 64'hBAD;
    #1;
    chk("stray_ready", 64'(ch_ready_o), 64'h8);
    chk("stray_err_pre", 64'(err_o), 64'h0);
    @(negedge clk);
    ch_valid_i = '0;
    #1;
    chk("stray_err", 64'(err_o), 64'h1);
    chk("stray_eng_valid", 64'(eng_valid_o), 64'h0);
    @(negedge clk);
    #1;
    chk("stray_err_post", 64'(err_o), 64'h0);
    chk("stray_eng_valid_post", 64'(eng_valid_o), 64'h0);

    // Engine stalls for 5 cycles in the middle of a 4-word packet on ch1.
    run_pkt(1, 4, 16'h100, 4, 5, 0, gn);
    check_pkt(1, 4, 16'h100, gn);

    // Reset after 2 of 4 words, then a fresh ch0 packet must come through intact.
    run_pkt(0, 4, 16'h200, 1000, 0, 2, gn);
    run_pkt(0, 3, 16'h300, 1000, 0, 0, gn);
    check_pkt(0, 3, 16'h300, gn);

`ifdef ZRLE_ARB_STATS_EN
    do_reset();
    for (int p = 0; p < 3; p++) begin
      run_pkt(2, 2, 16'h700 + 16'(p * 4), 1000, 0, 0, gn);
      check_pkt(2, 2, 16'h700 + 16'(p * 4), gn);
    end
    repeat (2) @(negedge clk);
    #1;
    for (int k = 0; k < 4; k++) begin
      chk($sformatf("pkt_cnt[%0d]", k), 64'(pkt_cnt_o[k*16 +: 16]), (k == 2) ? 64'd3 : 64'd0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
